sentinel_auth_fsm: RTL and testbench
====================================

// Module: sentinel_auth_fsm
// PURPOSE
// - Attempt-sequencing and lockout controller directly downstream of the Key Comparator.
// - Consumes the comparator's single-bit match result on each presented attempt.
// - Grants timed access on a match; applies a penalty delay on each mismatch.
// - Enters a permanent lockdown after MAX_FAILS consecutive mismatches; only a reset clears it.
// PARAMETERS
// - MAX_FAILS       3     consecutive mismatches that trigger LOCKDOWN (legal range 1..15)
// - PENALTY_CYCLES  1024  cycles spent in PENALTY after a non-final mismatch (>=1)
// - GRANT_CYCLES    256   maximum cycles spent in GRANTED before auto-relock (>=1)
// - FAIL_W          4     width of fail_count
// - TMR_W           16    width of timer; must hold max(PENALTY_CYCLES, GRANT_CYCLES)-1
// PORTS
// - clk            in   1       system clock, rising edge
// - rst_n          in   1       asynchronous active-low reset
// - attempt_valid  in   1       key presented this cycle; key_match is valid when this is high
// - key_match      in   1       comparator result (1 = keys equal)
// - relock         in   1       ends a GRANTED session early
// - attempt_ready  out  1       high only in ARMED
// - granted        out  1       high in GRANTED
// - penalty        out  1       high in PENALTY
// - lockdown       out  1       high in LOCKDOWN
// - fail_count     out  FAIL_W  consecutive mismatch count
// - timer          out  TMR_W   remaining cycles in GRANTED/PENALTY, else 0
// BEHAVIOUR
// - Reset (async assert, sync-release use): state=ARMED, fail_count=0, timer=0, attempt_ready=1, other outputs 0.
// - States: ARMED, GRANTED, PENALTY, LOCKDOWN. All outputs are registered or decoded from registered state only.
// - Attempt accepted iff attempt_valid & attempt_ready; attempt_valid in any other state is dropped, not queued.
// - Latency: attempt accepted at edge N -> new state and outputs visible after edge N (1 cycle).
// - ARMED, accept, key_match=1 -> GRANTED; fail_count<=0; timer<=GRANT_CYCLES-1.
// - ARMED, accept, key_match=0, fail_count+1 < MAX_FAILS -> PENALTY; fail_count+=1; timer<=PENALTY_CYCLES-1.
// - ARMED, accept, key_match=0, fail_count+1 == MAX_FAILS -> LOCKDOWN; fail_count<=MAX_FAILS; timer<=0.
// - GRANTED and PENALTY: timer decrements each cycle; when timer==0 -> ARMED. Each state therefore lasts exactly N cycles.
// - GRANTED, relock=1 -> ARMED next cycle; timer<=0. relock together with timer==0 -> ARMED once, no side effects.
// - relock is ignored in ARMED, PENALTY and LOCKDOWN.
// - PENALTY exit does not clear fail_count; only a match or a reset clears it.
// - LOCKDOWN is absorbing: all inputs are ignored; only rst_n exits it.
// - fail_count never exceeds MAX_FAILS.
// - MAX_FAILS=1: the first mismatch goes straight to LOCKDOWN; PENALTY is unreachable.
// - Reset asserted mid-GRANTED, mid-PENALTY or in LOCKDOWN -> immediate return to reset values; no state is retained.
// - Illegal state encoding -> LOCKDOWN (fail-secure).
// STRUCTURE
// - Shared include citadel_defs.vh holds:
//   - state encoding localparams: ST_ARMED=2'b00, ST_GRANTED=2'b01, ST_PENALTY=2'b10, ST_LOCKDOWN=2'b11
//   - default widths
// - One sub-module, citadel_down_timer (TMR_W), providing:
//   - ports: load, load_val, en, count, zero
//   - loadable down-counter that holds at 0
// - The FSM, fail counter and output decode live in sentinel_auth_fsm.
// TESTING
// - Match: reset; one attempt with key_match=1 -> granted=1 for exactly 256 cycles, then attempt_ready=1; fail_count=0.
// - Mismatch: one attempt with key_match=0 -> penalty=1 for 1024 cycles, fail_count=1; attempts during penalty are ignored.
// - Lockdown: 3 mismatches, each after its penalty -> lockdown=1, fail_count=3; a later match has no effect; rst_n low -> ARMED.
// - Relock: grant, then relock at timer=100 -> ARMED next cycle; relock at timer=0 -> single ARMED transition.
// - Clear count: 2 mismatches then 1 match -> fail_count=0; 2 further mismatches do not cause lockdown.
// - Async reset: rst_n pulsed low mid-PENALTY between clock edges -> outputs return to reset values before the next edge.

Source files
------------

// File: rtl/sentinel_auth_fsm_pkg.sv
// Shared state encoding and default sizing for the sentinel attempt/lockout controller.
// Every encoding of the 2-bit state is named, so recovery from corruption is handled in the FSM.
package sentinel_auth_fsm_pkg;

  localparam int DEF_MAX_FAILS      = 3;
  localparam int DEF_PENALTY_CYCLES = 1024;
  localparam int DEF_GRANT_CYCLES   = 256;
  localparam int DEF_FAIL_W         = 4;
  localparam int DEF_TMR_W          = 16;

  localparam logic [1:0] ST_ARMED    = 2'b00;
  localparam logic [1:0] ST_GRANTED  = 2'b01;
  localparam logic [1:0] ST_PENALTY  = 2'b10;
  localparam logic [1:0] ST_LOCKDOWN = 2'b11;

  typedef enum logic [1:0] {
    S_ARMED    = ST_ARMED,
    S_GRANTED  = ST_GRANTED,
    S_PENALTY  = ST_PENALTY,
    S_LOCKDOWN = ST_LOCKDOWN
  } state_t;

endpackage

// File: rtl/sentinel_auth_fsm_down_timer.sv
// Loadable down-counter that holds at zero; load wins over enable.
// zero is decoded combinationally from the registered count.
module citadel_down_timer #(
  parameter int TMR_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic [TMR_W-1:0] count,
  output logic             zero
);

  logic [TMR_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != '0)) begin
      r_count <= r_count - TMR_W'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/sentinel_auth_fsm.sv
// Attempt sequencing and lockout controller fed by the key comparator's match bit.
// Match grants a timed session, mismatch costs a penalty, MAX_FAILS in a row locks until reset.
module sentinel_auth_fsm
  import sentinel_auth_fsm_pkg::*;
#(
  parameter int MAX_FAILS      = DEF_MAX_FAILS,
  parameter int PENALTY_CYCLES = DEF_PENALTY_CYCLES,
  parameter int GRANT_CYCLES   = DEF_GRANT_CYCLES,
  parameter int FAIL_W         = DEF_FAIL_W,
  parameter int TMR_W          = DEF_TMR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              attempt_valid,
  input  logic              key_match,
  input  logic              relock,
  output logic              attempt_ready,
  output logic              granted,
  output logic              penalty,
  output logic              lockdown,
  output logic [FAIL_W-1:0] fail_count,
  output logic [TMR_W-1:0]  timer
);

  localparam logic [FAIL_W-1:0] LP_MAX_FAILS = FAIL_W'(MAX_FAILS);
  localparam logic [TMR_W-1:0]  LP_GRANT_LD  = TMR_W'(GRANT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LP_PEN_LD    = TMR_W'(PENALTY_CYCLES - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [FAIL_W-1:0] r_fail_count;
  logic [FAIL_W-1:0] w_fail_next;
  logic [FAIL_W:0]   w_fail_inc;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_load_val;
  logic              w_tmr_en;
  logic              w_tmr_zero;
  logic [TMR_W-1:0]  w_tmr_count;

  // One bit wider so a count already at the top of its range cannot wrap.
  assign w_fail_inc = {1'b0, r_fail_count} + {{FAIL_W{1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_ARMED;
      r_fail_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_fail_count <= w_fail_next;
    end
  end

  always_comb begin
    w_next_state   = r_state;
    w_fail_next    = r_fail_count;
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_en       = 1'b0;
    case (r_state)
      S_ARMED: begin
        if (attempt_valid) begin
          if (key_match) begin
            w_next_state   = S_GRANTED;
            w_fail_next    = '0;
            w_tmr_load     = 1'b1;
            w_tmr_load_val = LP_GRANT_LD;
          end else if (w_fail_inc >= {1'b0, LP_MAX_FAILS}) begin
            w_next_state = S_LOCKDOWN;
            w_fail_next  = LP_MAX_FAILS;
            w_tmr_load   = 1'b1;
          end else begin
            w_next_state   = S_PENALTY;
            w_fail_next    = w_fail_inc[FAIL_W-1:0];
            w_tmr_load     = 1'b1;
            w_tmr_load_val = LP_PEN_LD;
          end
        end
      end
      S_GRANTED: begin
        if (w_tmr_zero) begin
          w_next_state = S_ARMED;
        end else if (relock) begin
          w_next_state = S_ARMED;
          w_tmr_load   = 1'b1;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      S_PENALTY: begin
        if (w_tmr_zero) begin
          w_next_state = S_ARMED;
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      S_LOCKDOWN: begin
        w_next_state = S_LOCKDOWN;
      end
      default: begin
        // Corrupted state register fails secure.
        w_next_state = S_LOCKDOWN;
        w_tmr_load   = 1'b1;
      end
    endcase
  end

  citadel_down_timer #(
    .TMR_W(TMR_W)
  ) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (w_tmr_load),
    .load_val(w_tmr_load_val),
    .en      (w_tmr_en),
    .count   (w_tmr_count),
    .zero    (w_tmr_zero)
  );

  assign attempt_ready = (r_state == S_ARMED);
  assign granted       = (r_state == S_GRANTED);
  assign penalty       = (r_state == S_PENALTY);
  assign lockdown      = (r_state == S_LOCKDOWN);
  assign fail_count    = r_fail_count;
  assign timer         = w_tmr_count;

endmodule

// File: tb/tb_sentinel_auth_fsm.sv
// Directed bench for sentinel_auth_fsm at default parameters.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_sentinel_auth_fsm;

  logic        clk;
  logic        rst_n;
  logic        attempt_valid;
  logic        key_match;
  logic        relock;
  logic        attempt_ready;
  logic        granted;
  logic        penalty;
  logic        lockdown;
  logic [3:0]  fail_count;
  logic [15:0] timer;

  int n_checks;
  int n_fail;
  int cnt;

  sentinel_auth_fsm dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .attempt_valid(attempt_valid),
    .key_match    (key_match),
    .relock       (relock),
    .attempt_ready(attempt_ready),
    .granted      (granted),
    .penalty      (penalty),
    .lockdown     (lockdown),
    .fail_count   (fail_count),
    .timer        (timer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic attempt(input logic m);
    attempt_valid = 1'b1;
    key_match     = m;
    tick();
    attempt_valid = 1'b0;
    key_match     = 1'b0;
  endtask

  task automatic chk_armed(input string tag, input logic [3:0] fc);
    chk({tag, "_ready"}, 32'(attempt_ready), 32'd1);
    chk({tag, "_busy"}, 32'({granted, penalty, lockdown}), 32'd0);
    chk({tag, "_fail"}, 32'(fail_count), 32'(fc));
    chk({tag, "_timer"}, 32'(timer), 32'd0);
  endtask

  task automatic wait_penalty_end(input string tag);
    int c;
    c = 0;
    while (penalty && c < 2000) begin
      c++;
      tick();
    end
    chk({tag, "_pen_end"}, 32'(penalty), 32'd0);
  endtask

  task automatic wait_grant_end(input string tag);
    int c;
    c = 0;
    while (granted && c < 400) begin
      c++;
      tick();
    end
    chk({tag, "_grant_end"}, 32'(granted), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    attempt_valid = 1'b0;
    key_match     = 1'b0;
    relock        = 1'b0;
    #1;
    chk_armed("rst_async", 4'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk_armed("rst", 4'd0);

    // Match: 256-cycle grant, then back to ARMED.
    attempt(1'b1);
    chk("match_granted", 32'(granted), 32'd1);
    chk("match_ready", 32'(attempt_ready), 32'd0);
    chk("match_timer", 32'(timer), 32'd255);
    cnt = 0;
    while (granted && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("match_len", 32'(cnt), 32'd256);
    chk_armed("match_after", 4'd0);

    // Mismatch: 1024-cycle penalty, attempts dropped meanwhile.
    attempt(1'b0);
    chk("mis_penalty", 32'(penalty), 32'd1);
    chk("mis_fail", 32'(fail_count), 32'd1);
    chk("mis_timer", 32'(timer), 32'd1023);
    attempt_valid = 1'b1;
    key_match     = 1'b1;
    repeat (10) tick();
    attempt_valid = 1'b0;
    key_match     = 1'b0;
    chk("mis_drop_pen", 32'(penalty), 32'd1);
    chk("mis_drop_grant", 32'(granted), 32'd0);
    chk("mis_drop_timer", 32'(timer), 32'd1013);
    cnt = 0;
    while (penalty && cnt < 2000) begin
      cnt++;
      tick();
    end
    chk("mis_len", 32'(cnt), 32'd1014);
    chk_armed("mis_after", 4'd1);

    // Lockdown after three consecutive mismatches.
    do_reset();
    attempt(1'b0);
    wait_penalty_end("lk1");
    attempt(1'b0);
    chk("lk2_fail", 32'(fail_count), 32'd2);
    wait_penalty_end("lk2");
    attempt(1'b0);
    chk("lk_lockdown", 32'(lockdown), 32'd1);
    chk("lk_fail", 32'(fail_count), 32'd3);
    chk("lk_timer", 32'(timer), 32'd0);
    chk("lk_ready", 32'(attempt_ready), 32'd0);
    attempt_valid = 1'b1;
    key_match     = 1'b1;
    relock        = 1'b1;
    repeat (5) tick();
    attempt_valid = 1'b0;
    key_match     = 1'b0;
    relock        = 1'b0;
    chk("lk_hold", 32'(lockdown), 32'd1);
    chk("lk_hold_grant", 32'(granted), 32'd0);
    chk("lk_hold_fail", 32'(fail_count), 32'd3);
    do_reset();
    chk_armed("lk_reset", 4'd0);

    // Relock mid-session at timer=100.
    attempt(1'b1);
    cnt = 0;
    while (timer != 16'd100 && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("rl_reach100", 32'(timer), 32'd100);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk_armed("rl100", 4'd0);

    // Relock coinciding with timer==0: one transition, then ignored in ARMED.
    attempt(1'b1);
    cnt = 0;
    while (timer != 16'd0 && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("rl0_last", 32'(granted), 32'd1);
    relock = 1'b1;
    tick();
    chk_armed("rl0", 4'd0);
    tick();
    relock = 1'b0;
    chk_armed("rl0_hold", 4'd0);

    // A match clears the count; two more mismatches stay short of lockdown.
    do_reset();
    attempt(1'b0);
    wait_penalty_end("cc1");
    attempt(1'b0);
    wait_penalty_end("cc2");
    chk("cc_fail2", 32'(fail_count), 32'd2);
    attempt(1'b1);
    chk("cc_clear", 32'(fail_count), 32'd0);
    wait_grant_end("cc_g");
    attempt(1'b0);
    wait_penalty_end("cc3");
    attempt(1'b0);
    chk("cc_no_lock", 32'(lockdown), 32'd0);
    chk("cc_pen", 32'(penalty), 32'd1);
    chk("cc_fail_again", 32'(fail_count), 32'd2);
    wait_penalty_end("cc4");
    chk_armed("cc_after", 4'd2);

    // Asynchronous reset between edges during PENALTY.
    do_reset();
    attempt(1'b0);
    repeat (3) tick();
    chk("ar_pen", 32'(penalty), 32'd1);
    #1;
    rst_n = 1'b0;
    #2;
    chk_armed("ar_mid", 4'd0);
    rst_n = 1'b1;
    tick();
    chk_armed("ar_after", 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
